// File: rtl/p_x_seq_if.sv
// p_x_seq_if: enter/set/control inputs and state/strobe outputs of the P-X state control unit
interface p_x_seq_if #(
    parameter int NST = 20
);
    logic [NST-1:0] enter;
    logic [NST-1:0] set;
    logic           mode;
    logic           step;
    logic           strob_fp;
    logic           ok;
    logic [NST-1:0] state;
    logic           strob1;
    logic           strob2;
    logic           got;
    logic           alarm;
    logic           hold;

    modport master (
        output enter, set, mode, step, strob_fp, ok,
        input  state, strob1, strob2, got, alarm, hold
    );

    modport slave (
        input  enter, set, mode, step, strob_fp, ok,
        output state, strob1, strob2, got, alarm, hold
    );
endinterface

// File: rtl/p_x_seq.sv
// p_x_seq: one-hot CPU state register bank with synchronous STROB1/STROB2/bus-wait/step/GOT timing
module p_x_seq #(
    parameter int             NST       = 20,
    parameter logic [NST-1:0] RST_ST    = NST'(1),
    parameter logic [NST-1:0] LONG_MASK = '0,
    parameter logic [NST-1:0] BUS_MASK  = '0,
    parameter int             S1_LEN    = 2,
    parameter int             S2_LEN    = 2,
    parameter int             TMO       = 255
) (
    input logic      clk_i,
    input logic      clo_i,
    p_x_seq_if.slave bus
);
    localparam int MAX_S = (S1_LEN > S2_LEN) ? S1_LEN : S2_LEN;
    localparam int MAXC  = (MAX_S > TMO) ? MAX_S : TMO;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {P_RST, P_IDLE, P_S1, P_S2, P_BUS, P_STEP, P_GOT} phase_e;

    phase_e         phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NST-1:0] state_q, state_d;
    logic           step_q;
    logic           strob1_q, strob1_d;
    logic           strob2_q, strob2_d;
    logic           got_q, got_d;
    logic           alarm_q, alarm_d;
    logic           hold_q, hold_d;
    logic           long_w, bus_w, step_edge_w;
    phase_e         fin_w, after_s2_w, after_s1_w;

    assign long_w      = |(state_q & LONG_MASK);
    assign bus_w       = |(state_q & BUS_MASK);
    assign step_edge_w = bus.step & ~step_q;
    assign fin_w       = bus.mode ? P_STEP : P_GOT;
    assign after_s2_w  = bus_w ? P_BUS : fin_w;
    assign after_s1_w  = long_w ? P_S2 : after_s2_w;

    // Phase sequencing, state loading and registered phase outputs
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            P_RST:   phase_d = P_S1;
            P_IDLE:  phase_d = |bus.set ? P_S1 : P_IDLE;
            P_S1:    phase_d = (cnt_q == CW'(S1_LEN - 1)) ? after_s1_w : P_S1;
            P_S2:    phase_d = (cnt_q == CW'(S2_LEN - 1)) ? after_s2_w : P_S2;
            P_BUS:   phase_d = (bus.ok || cnt_q == CW'(TMO)) ? fin_w : P_BUS;
            P_STEP:  phase_d = (step_edge_w || !bus.mode) ? P_GOT : P_STEP;
            P_GOT:   phase_d = |(bus.enter | bus.set) ? P_S1 : P_IDLE;
            default: phase_d = P_RST;
        endcase
        state_d  = (phase_q == P_GOT) ? (bus.enter | bus.set) : (state_q | bus.set);
        cnt_d    = (phase_d == phase_q && (phase_q == P_S1 || phase_q == P_S2 || phase_q == P_BUS))
                   ? cnt_q + 1'b1 : '0;
        strob1_d = (phase_d == P_S1) || (phase_q == P_STEP && phase_d == P_STEP && bus.strob_fp);
        strob2_d = (phase_d == P_S2);
        got_d    = (phase_d == P_GOT);
        alarm_d  = (phase_d == P_BUS) && (cnt_d == CW'(TMO));
        hold_d   = (phase_d == P_STEP) || (phase_d == P_IDLE);
    end

    // Register bank; clo clears everything and parks the sequencer one clock before S1
    always_ff @(posedge clk_i) begin
        if (clo_i) begin
            phase_q  <= P_RST;
            cnt_q    <= '0;
            state_q  <= RST_ST;
            step_q   <= 1'b0;
            strob1_q <= 1'b0;
            strob2_q <= 1'b0;
            got_q    <= 1'b0;
            alarm_q  <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            step_q   <= bus.step;
            strob1_q <= strob1_d;
            strob2_q <= strob2_d;
            got_q    <= got_d;
            alarm_q  <= alarm_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.state  = state_q;
    assign bus.strob1 = strob1_q;
    assign bus.strob2 = strob2_q;
    assign bus.got    = got_q;
    assign bus.alarm  = alarm_q;
    assign bus.hold   = hold_q;
endmodule

// File: tb/tb_p_x_seq.sv
// tb_p_x_seq: table, hand-written and randomized checks of the P-X sequencer timing
module tb_p_x_seq;
    localparam logic [19:0] LONG_M = 20'h2;
    localparam logic [19:0] BUS_M  = 20'h4;
    localparam int          S1     = 2;
    localparam int          S2     = 2;
    localparam int          TO     = 4;

    logic clk = 1'b0;
    logic clo = 1'b1;
    always #5 clk = ~clk;

    p_x_seq_if #(.NST(20)) pif ();

    p_x_seq #(
        .NST(20), .RST_ST(20'h1), .LONG_MASK(LONG_M), .BUS_MASK(BUS_M),
        .S1_LEN(S1), .S2_LEN(S2), .TMO(TO)
    ) dut (
        .clk_i(clk),
        .clo_i(clo),
        .bus  (pif)
    );

    typedef struct {
        logic [19:0] st;
        logic [19:0] nxt;
        int          ok_off;
        int          len;
        int          s1;
        int          s2;
        int          al;
    } vec_t;

    vec_t        tbl [7];
    int          total  = 0;
    int          passed = 0;
    int          n, s2c, acc;
    logic [19:0] cur, nxt;
    int          pre, k, bl, oo;
    bit          lg, bs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic logic [31:0] outs();
        return {7'b0, pif.state, pif.strob1, pif.strob2, pif.got, pif.alarm, pif.hold};
    endfunction

    // One machine cycle from its first S1 clock, ok pulsed at a chosen offset
    task automatic machine(input logic [19:0] st, input logic [19:0] nx, input int ok_off,
                           input int e_len, input int e_s1, input int e_s2, input int e_al,
                           input string tag, input int idx);
        int  c = 0, a1 = 0, a2 = 0, aa = 0;
        bit  done = 0;
        chk($sformatf("%s%0d_state", tag, idx), 32'(pif.state), 32'(st));
        pif.enter = nx;
        while (!done && c < 40) begin
            pif.ok = (c == ok_off);
            a1 += int'(pif.strob1);
            a2 += int'(pif.strob2);
            aa += int'(pif.alarm);
            if (pif.got) done = 1;
            c++;
            @(negedge clk);
        end
        pif.ok = 1'b0;
        chk($sformatf("%s%0d_len", tag, idx), 32'(c), 32'(e_len));
        chk($sformatf("%s%0d_strob1", tag, idx), 32'(a1), 32'(e_s1));
        chk($sformatf("%s%0d_strob2", tag, idx), 32'(a2), 32'(e_s2));
        chk($sformatf("%s%0d_alarm", tag, idx), 32'(aa), 32'(e_al));
    endtask

    // Clocks from now up to and including the next got, leaving us at the next cycle start
    task automatic run_to_got(output int cnt, output int s2n);
        bit done = 0;
        cnt = 0;
        s2n = 0;
        while (!done && cnt < 40) begin
            s2n += int'(pif.strob2);
            if (pif.got) done = 1;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        pif.enter    = 20'h1;
        pif.set      = '0;
        pif.mode     = 1'b0;
        pif.step     = 1'b0;
        pif.strob_fp = 1'b0;
        pif.ok       = 1'b0;
        tbl[0] = '{20'h1, 20'h2, -1, 3, 2, 0, 0};
        tbl[1] = '{20'h2, 20'h2, -1, 5, 2, 2, 0};
        tbl[2] = '{20'h2, 20'h4, -1, 5, 2, 2, 0};
        tbl[3] = '{20'h4, 20'h4, -1, 8, 2, 0, 1};
        tbl[4] = '{20'h4, 20'h6,  5, 7, 2, 0, 0};
        tbl[5] = '{20'h6, 20'h1,  4, 6, 2, 2, 0};
        tbl[6] = '{20'h1, 20'h1,  0, 3, 2, 0, 0};

        clo = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset", outs(), {7'b0, 20'h1, 5'b0});
        clo = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            machine(tbl[i].st, tbl[i].nxt, tbl[i].ok_off, tbl[i].len, tbl[i].s1, tbl[i].s2,
                    tbl[i].al, "tbl", i);

        pif.set = 20'h2;
        @(negedge clk);
        pif.set = '0;
        chk("set_or", 32'(pif.state), 32'h3);
        run_to_got(n, s2c);
        chk("set_len", 32'(n), 32'd4);
        chk("set_s2", 32'(s2c), 32'd2);

        pif.mode = 1'b1;
        pif.step = 1'b1;
        repeat (2) @(negedge clk);
        chk("step_hold", 32'({pif.hold, pif.strob1}), 32'b10);
        acc = 0;
        repeat (3) begin @(negedge clk); acc += int'(pif.got); end
        chk("step_held_no_got", 32'(acc), 32'd0);
        acc = 0;
        pif.strob_fp = 1'b1;
        @(negedge clk); acc += int'(pif.strob1);
        @(negedge clk); acc += int'(pif.strob1);
        pif.strob_fp = 1'b0;
        @(negedge clk); acc += int'(pif.strob1);
        @(negedge clk); acc += int'(pif.strob1);
        chk("fp_strobes", 32'(acc), 32'd2);
        chk("fp_state_hold", 32'({pif.state, pif.hold, pif.got}), 32'({20'h1, 2'b10}));
        pif.enter = 20'h8;
        pif.step  = 1'b0;
        @(negedge clk);
        pif.step = 1'b1;
        acc = 0;
        repeat (8) begin @(negedge clk); acc += int'(pif.got); end
        chk("step_once", 32'(acc), 32'd1);
        chk("step_state", 32'({pif.state, pif.hold}), 32'({20'h8, 1'b1}));
        pif.mode = 1'b0;
        run_to_got(n, s2c);
        chk("mode_drop", 32'(n), 32'd2);

        pif.enter = '0;
        run_to_got(n, s2c);
        chk("pre_idle_len", 32'(n), 32'd3);
        chk("idle_state_hold", 32'({pif.state, pif.hold}), 32'({20'h0, 1'b1}));
        acc = 0;
        repeat (3) begin @(negedge clk); acc += int'(pif.strob1) + int'(pif.strob2) + int'(pif.got); end
        chk("idle_quiet", 32'(acc), 32'd0);
        pif.set = 20'h10;
        @(negedge clk);
        pif.set   = '0;
        pif.enter = 20'h1;
        chk("idle_set", 32'({pif.state, pif.strob1, pif.hold}), 32'({20'h10, 2'b10}));
        run_to_got(n, s2c);
        chk("idle_exit_len", 32'(n), 32'd3);

        pif.enter = 20'h2;
        run_to_got(n, s2c);
        repeat (2) @(negedge clk);
        chk("s2_before_clo", 32'(pif.strob2), 32'd1);
        clo = 1'b1;
        @(negedge clk);
        chk("clo_mid_s2", outs(), {7'b0, 20'h1, 5'b0});
        clo = 1'b0;
        pif.enter = 20'h4;
        @(negedge clk);
        run_to_got(n, s2c);
        chk("post_clo_len", 32'(n), 32'd3);
        repeat (3) @(negedge clk);
        clo = 1'b1;
        @(negedge clk);
        chk("clo_mid_bus", outs(), {7'b0, 20'h1, 5'b0});
        clo = 1'b0;
        pif.enter = 20'h1;
        acc = 0;
        repeat (12) begin @(negedge clk); acc += int'(pif.alarm); end
        chk("no_alarm_after_clo", 32'(acc), 32'd0);
        @(negedge clk);

        cur = 20'h1;
        for (int i = 0; i < 40; i++) begin
            nxt = 20'($urandom_range(1, 15));
            lg  = |(cur & LONG_M);
            bs  = |(cur & BUS_M);
            pre = S1 + (lg ? S2 : 0);
            k   = $urandom_range(1, TO + 2);
            bl  = bs ? ((k <= TO) ? k : TO + 1) : 0;
            oo  = bs ? ((k <= TO) ? pre + k - 1 : -1) : int'($urandom_range(0, 2));
            machine(cur, nxt, oo, pre + bl + 1, S1, lg ? S2 : 0, (bs && k > TO) ? 1 : 0, "rnd", i);
            cur = nxt;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
